regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port integer register file with a per-register busy
//  scoreboard, for the dtcore32 decode/writeback stages. Replaces the fixed
//  2R1W 32x32 file. Adds: write enable, N read ports, and pending-write tracking
//  so decode can detect RAW hazards. Optional same-cycle write-to-read bypass.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  register count; power of two, >= 2; AW = $clog2(NREGS)
//  NUM_RD   2   number of combinational read ports, 1..4
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never busy; 0: normal reg
// PORTS
//  clk_i          in   1            clock, all state updates on rising edge
//  rst_i          in   1            synchronous reset, active-high
//  rs_addr_i      in   NUM_RD*AW    read addresses; port k = [k*AW +: AW]
//  rs_rdata_o     out  NUM_RD*XLEN  read data; port k = [k*XLEN +: XLEN]
//  rs_busy_o      out  NUM_RD       1 = register on port k has a pending write
//  issue_en_i     in   1            decode issues an instruction writing issue_addr_i
//  issue_addr_i   in   AW           destination register of issued instruction
//  wr_en_i        in   1            writeback strobe
//  rd_addr_i      in   AW           writeback destination
//  reg_wr_data_i  in   XLEN         writeback data
//  busy_vec_o     out  NREGS        registered busy bits, bit i = register i
// BEHAVIOUR
//  State: reg_q[NREGS][XLEN], busy_q[NREGS]. No FSM; per-entry set/clear logic.
//  Reset (rst_i=1 at edge): all reg_q = 0, all busy_q = 0. Overrides every
//   other input that cycle. After reset: rs_rdata_o = 0, rs_busy_o = 0,
//   busy_vec_o = 0.
//  Write: at edge, if wr_en_i and not (ZERO_REG and rd_addr_i==0):
//   reg_q[rd_addr_i] <= reg_wr_data_i. wr_en_i=0 -> no register changes.
//  Read: combinational, rs_rdata_o[k] = reg_q[rs_addr_i[k]]; 0 if ZERO_REG and
//   address 0. Ports independent; identical addresses on several ports legal.
//  Scoreboard, per register i, at edge:
//   set   = issue_en_i  and issue_addr_i==i
//   clear = wr_en_i     and rd_addr_i==i
//   set wins over clear (new producer issued same cycle old one retires).
//   ZERO_REG=1: busy_q[0] held 0, issue to x0 ignored.
//   Issue to an already-busy register: stays busy (single bit, no counting).
//   Writeback to a non-busy register: data written, busy stays 0.
//  rs_busy_o[k] = busy_q[rs_addr_i[k]] (modified by bypass, below).
//  busy_vec_o = busy_q, always registered, never bypassed.
//  Latency: write visible on read ports 1 cycle after the write edge
//   (0 cycles with bypass). Busy set visible 1 cycle after issue edge.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if wr_en_i and rd_addr_i==rs_addr_i[k] (and
//   not the zero register), rs_rdata_o[k] = reg_wr_data_i and rs_busy_o[k] = 0
//   in the same cycle, unless issue_en_i targets the same register that cycle
//   (then rs_busy_o[k] = 1, data still bypassed).
//  Not defined: read ports show only reg_q/busy_q; same-cycle write is not
//   visible until the next cycle. Sequential state identical in both builds.
// TESTING
//  1 Reset: write x5=0xDEAD, assert rst_i 1 cycle -> all ports read 0,
//    busy_vec_o=0.
//  2 Write/read: wr x7=0x1234_5678, next cycle rs_addr port0=7, port1=7 ->
//    both 0x1234_5678; wr x0=0xFFFF_FFFF -> x0 reads 0 (ZERO_REG=1).
//  3 Scoreboard: issue x3 -> next cycle busy_vec_o[3]=1, rs_busy_o=1 on x3;
//    wr x3=0xA5 -> next cycle busy 0, data 0xA5; issue x0 -> busy_vec_o[0]=0.
//  4 Simultaneous: x4 busy, same cycle issue x4 and wr x4=0x11 -> x4 reads 0x11,
//    busy_vec_o[4] stays 1; wr_en_i=0 with rd_addr_i=4 -> no change.
//  5 Bypass: wr x9=0xCAFE with port0 addr 9 same cycle -> defined: port0=0xCAFE,
//    rs_busy_o[0]=0; undefined: port0=old value (0) until next cycle.
//  6 Params: NREGS=16, NUM_RD=3, XLEN=64, ZERO_REG=0 -> x0 writable
//    (wr 0x1 reads 0x1), x15 write/read and busy on all 3 ports correct.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with N combinational read ports, one write port and a
// per-register busy scoreboard. Decode uses the scoreboard to detect RAW
// hazards: an issue sets the destination's busy bit, and writeback clears it.
//
// Parameters
//   XLEN      data width in bits
//   NREGS     register count (power of two, >= 2)
//   NUM_RD    number of read ports (1..4)
//   ZERO_REG  1: register 0 is hard-wired to zero and is never busy
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   rst_i          synchronous active-high reset; clears data and busy bits
//   rs_addr_i      read addresses, port k at [k*AW +: AW]
//   rs_rdata_o     read data, port k at [k*XLEN +: XLEN]
//   rs_busy_o      busy flag of the register addressed by port k
//   issue_en_i     an instruction writing issue_addr_i is issued this cycle
//   issue_addr_i   destination register of the issued instruction
//   wr_en_i        writeback strobe
//   rd_addr_i      writeback destination
//   reg_wr_data_i  writeback data
//   busy_vec_o     registered busy bits, bit i = register i (never bypassed)
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a writeback in the current cycle is
//                      forwarded to any read port addressing the same register
//                      (data and busy). Sequential state is the same in both
//                      builds.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_RD*$clog2(NREGS)-1:0] rs_addr_i,
  output logic [NUM_RD*XLEN-1:0]      rs_rdata_o,
  output logic [NUM_RD-1:0]           rs_busy_o,
  input  logic                        issue_en_i,
  input  logic [$clog2(NREGS)-1:0]    issue_addr_i,
  input  logic                        wr_en_i,
  input  logic [$clog2(NREGS)-1:0]    rd_addr_i,
  input  logic [XLEN-1:0]             reg_wr_data_i,
  output logic [NREGS-1:0]            busy_vec_o
);

  localparam int AW = $clog2(NREGS);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  regfile_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Writeback is dropped entirely when it targets the hard-wired zero register.
  logic wr_is_zero;
  logic wr_commit;

  assign wr_is_zero = HAS_ZERO && (rd_addr_i == '0);
  assign wr_commit  = wr_en_i && !wr_is_zero;

  // ---------------------------------------------------------------------------
  // Data array. Read ports are combinational, so this stays a plain register
  // array rather than a block RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regfile_reg[i] <= '0;
      end
    end else if (wr_commit) begin
      regfile_reg[rd_addr_i] <= reg_wr_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: one set/clear pair per register.
  // Set has priority so that a new producer issued in the same cycle the old
  // one retires keeps the register marked busy.
  // ---------------------------------------------------------------------------
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      assign set_vec[gi] = issue_en_i && (issue_addr_i == AW'(gi));
      assign clr_vec[gi] = wr_en_i    && (rd_addr_i    == AW'(gi));

      if (HAS_ZERO && (gi == 0)) begin : g_zero
        // The zero register never has a pending producer.
        assign busy_next[gi] = 1'b0;
      end else begin : g_norm
        assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec_o = busy_reg;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   port_addr;
      logic            port_is_zero;
      logic [XLEN-1:0] stored_data;
      logic            stored_busy;

      assign port_addr    = rs_addr_i[gi*AW +: AW];
      assign port_is_zero = HAS_ZERO && (port_addr == '0);

      // Force zero explicitly so the zero register reads 0 even before the
      // first reset has cleared the array.
      assign stored_data = port_is_zero ? '0   : regfile_reg[port_addr];
      assign stored_busy = port_is_zero ? 1'b0 : busy_reg[port_addr];

`ifdef REGFILE_BYPASS_EN
      // Forward the writeback in flight. The producer has retired, so the
      // register is no longer busy -- unless a new producer for the same
      // register is issued in this very cycle.
      logic byp_hit;
      logic byp_reissue;

      assign byp_hit     = wr_commit && (rd_addr_i == port_addr);
      assign byp_reissue = issue_en_i && (issue_addr_i == port_addr);

      assign rs_rdata_o[gi*XLEN +: XLEN] = byp_hit ? reg_wr_data_i : stored_data;
      assign rs_busy_o[gi]               = byp_hit ? byp_reissue   : stored_busy;
`else
      assign rs_rdata_o[gi*XLEN +: XLEN] = stored_data;
      assign rs_busy_o[gi]               = stored_busy;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Drives two instances of regfile_sb: the default configuration (d=0:
// 32 x 32-bit, 2 read ports, zero register) and a reduced one (d=1:
// 16 x 64-bit, 3 read ports, no zero register). A per-instance array model
// tracks register contents and pending writes; every cycle all read ports and
// the busy vector are compared against it.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Stimulus per instance (d = 0 / 1), widest sizes, narrowed when driven.
  logic [4:0]  s_rs_addr [2][4];
  logic        s_wr_en   [2];
  logic [4:0]  s_rd      [2];
  logic [63:0] s_wdata   [2];
  logic        s_iss_en  [2];
  logic [4:0]  s_iss     [2];

  // Instance A ports
  logic [9:0]   a_rs_addr;
  logic [63:0]  a_rdata;
  logic [1:0]   a_rs_busy;
  logic [4:0]   a_iss_addr, a_rd_addr;
  logic [31:0]  a_wdata;
  logic [31:0]  a_busy_vec;

  // Instance B ports
  logic [11:0]  b_rs_addr;
  logic [191:0] b_rdata;
  logic [2:0]   b_rs_busy;
  logic [3:0]   b_iss_addr, b_rd_addr;
  logic [63:0]  b_wdata;
  logic [15:0]  b_busy_vec;

  always_comb begin
    a_rs_addr  = {s_rs_addr[0][1], s_rs_addr[0][0]};
    a_iss_addr = s_iss[0];
    a_rd_addr  = s_rd[0];
    a_wdata    = s_wdata[0][31:0];
    b_rs_addr  = {s_rs_addr[1][2][3:0], s_rs_addr[1][1][3:0], s_rs_addr[1][0][3:0]};
    b_iss_addr = s_iss[1][3:0];
    b_rd_addr  = s_rd[1][3:0];
    b_wdata    = s_wdata[1];
  end

  regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .ZERO_REG(1)) u_dut_a (
    .clk_i         (clk),
    .rst_i         (rst),
    .rs_addr_i     (a_rs_addr),
    .rs_rdata_o    (a_rdata),
    .rs_busy_o     (a_rs_busy),
    .issue_en_i    (s_iss_en[0]),
    .issue_addr_i  (a_iss_addr),
    .wr_en_i       (s_wr_en[0]),
    .rd_addr_i     (a_rd_addr),
    .reg_wr_data_i (a_wdata),
    .busy_vec_o    (a_busy_vec)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NUM_RD(3), .ZERO_REG(0)) u_dut_b (
    .clk_i         (clk),
    .rst_i         (rst),
    .rs_addr_i     (b_rs_addr),
    .rs_rdata_o    (b_rdata),
    .rs_busy_o     (b_rs_busy),
    .issue_en_i    (s_iss_en[1]),
    .issue_addr_i  (b_iss_addr),
    .wr_en_i       (s_wr_en[1]),
    .rd_addr_i     (b_rd_addr),
    .reg_wr_data_i (b_wdata),
    .busy_vec_o    (b_busy_vec)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [63:0] m_regs [2][32];
  bit          m_busy [2][32];
  bit          model_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic int nrd(int d);  return (d == 0) ? 2  : 3;  endfunction
  function automatic int nreg(int d); return (d == 0) ? 32 : 16; endfunction
  function automatic bit zr(int d);   return (d == 0);           endfunction
  function automatic logic [63:0] mask(int d, logic [63:0] v);
    return (d == 0) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rdata(int d, int k);
    int a = int'(s_rs_addr[d][k]);
    if (zr(d) && a == 0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (s_wr_en[d] && int'(s_rd[d]) == a) return mask(d, s_wdata[d]);
`endif
    return m_regs[d][a];
  endfunction

  function automatic bit exp_busy(int d, int k);
    int a = int'(s_rs_addr[d][k]);
    if (zr(d) && a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (s_wr_en[d] && int'(s_rd[d]) == a) return s_iss_en[d] && int'(s_iss[d]) == a;
`endif
    return m_busy[d][a];
  endfunction

  function automatic logic [63:0] obs_rdata(int d, int k);
    if (d == 0) return {32'b0, a_rdata[k*32 +: 32]};
    return b_rdata[k*64 +: 64];
  endfunction

  task automatic check_outputs();
    logic [31:0] exp_vec;
    logic [31:0] obs_vec;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nrd(d); k++) begin
        check($sformatf("d%0d rdata%0d x%0d", d, k, s_rs_addr[d][k]),
              obs_rdata(d, k), exp_rdata(d, k));
        check($sformatf("d%0d rs_busy%0d x%0d", d, k, s_rs_addr[d][k]),
              64'((d == 0) ? a_rs_busy[k] : b_rs_busy[k]), 64'(exp_busy(d, k)));
      end
      exp_vec = '0;
      for (int i = 0; i < nreg(d); i++) exp_vec[i] = m_busy[d][i];
      obs_vec = (d == 0) ? a_busy_vec : {16'b0, b_busy_vec};
      check($sformatf("d%0d busy_vec", d), 64'(obs_vec), 64'(exp_vec));
    end
  endtask

  // Architectural effect of one clock edge, from the register-file rules:
  // retire clears busy, then issue marks busy (so issue wins).
  task automatic model_update();
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 32; i++) begin
          m_regs[d][i] = '0;
          m_busy[d][i] = 1'b0;
        end
      model_valid = 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (s_wr_en[d] && !(zr(d) && s_rd[d] == 0)) m_regs[d][s_rd[d]] = mask(d, s_wdata[d]);
        if (s_wr_en[d])  m_busy[d][s_rd[d]] = 1'b0;
        if (s_iss_en[d]) m_busy[d][s_iss[d]] = 1'b1;
        if (zr(d))       m_busy[d][0] = 1'b0;
      end
    end
  endtask

  // One clock: compare current outputs, take the edge, update model.
  task automatic step();
    if (model_valid) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      s_wr_en[d]  = 1'b0;
      s_iss_en[d] = 1'b0;
      s_rd[d]     = '0;
      s_iss[d]    = '0;
      s_wdata[d]  = '0;
      for (int k = 0; k < 4; k++) s_rs_addr[d][k] = '0;
    end
  endtask

  function automatic logic [4:0] rnd_addr(int d);
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, nreg(d) - 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;

    // Reset clears a previously written register
    s_wr_en[0] = 1'b1; s_rd[0] = 5'd5; s_wdata[0] = 64'hDEAD;
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0; s_rs_addr[0][0] = 5'd5;
    #1;
    check("rst x5 reads 0", 64'(a_rdata[31:0]), 64'd0);
    check("rst busy_vec 0", 64'(a_busy_vec), 64'd0);
    step();

    // Write then read on both ports; zero register ignores writes
    s_wr_en[0] = 1'b1; s_rd[0] = 5'd7; s_wdata[0] = 64'h1234_5678;
    step();
    idle(); s_rs_addr[0][0] = 5'd7; s_rs_addr[0][1] = 5'd7;
    #1;
    check("x7 port0", 64'(a_rdata[31:0]),  64'h1234_5678);
    check("x7 port1", 64'(a_rdata[63:32]), 64'h1234_5678);
    s_wr_en[0] = 1'b1; s_rd[0] = 5'd0; s_wdata[0] = 64'hFFFF_FFFF;
    step();
    idle();
    #1;
    check("x0 reads 0", 64'(a_rdata[31:0]), 64'd0);

    // Scoreboard set / clear; issue to x0 ignored
    s_iss_en[0] = 1'b1; s_iss[0] = 5'd3;
    step();
    idle(); s_rs_addr[0][0] = 5'd3;
    #1;
    check("x3 busy_vec", 64'(a_busy_vec[3]), 64'd1);
    check("x3 rs_busy",  64'(a_rs_busy[0]),  64'd1);
    s_wr_en[0] = 1'b1; s_rd[0] = 5'd3; s_wdata[0] = 64'hA5;
    step();
    idle(); s_rs_addr[0][0] = 5'd3;
    #1;
    check("x3 cleared", 64'(a_busy_vec[3]), 64'd0);
    check("x3 data",    64'(a_rdata[31:0]), 64'hA5);
    s_iss_en[0] = 1'b1; s_iss[0] = 5'd0;
    step();
    idle();
    #1;
    check("x0 never busy", 64'(a_busy_vec[0]), 64'd0);

    // Issue and writeback to the same busy register in one cycle
    s_iss_en[0] = 1'b1; s_iss[0] = 5'd4;
    step();
    s_wr_en[0] = 1'b1; s_rd[0] = 5'd4; s_wdata[0] = 64'h11;
    step();
    idle(); s_rs_addr[0][0] = 5'd4;
    #1;
    check("x4 data 0x11",   64'(a_rdata[31:0]), 64'h11);
    check("x4 still busy",  64'(a_busy_vec[4]), 64'd1);
    s_rd[0] = 5'd4; s_wdata[0] = 64'h99;
    step();
    #1;
    check("x4 wr_en=0 kept", 64'(a_rdata[31:0]), 64'h11);

    // Same-cycle write and read of x9
    idle();
    s_wr_en[0] = 1'b1; s_rd[0] = 5'd9; s_wdata[0] = 64'hCAFE; s_rs_addr[0][0] = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x9 bypass data", 64'(a_rdata[31:0]), 64'hCAFE);
    check("x9 bypass busy", 64'(a_rs_busy[0]),  64'd0);
`else
    check("x9 old data",    64'(a_rdata[31:0]), 64'd0);
`endif
    step();
    idle(); s_rs_addr[0][0] = 5'd9;
    #1;
    check("x9 next cycle", 64'(a_rdata[31:0]), 64'hCAFE);

    // Reduced configuration: x0 is an ordinary register, x15 on all ports
    s_wr_en[1] = 1'b1; s_rd[1] = 5'd0; s_wdata[1] = 64'h1;
    step();
    idle();
    #1;
    check("b x0 writable", b_rdata[63:0], 64'h1);
    s_wr_en[1] = 1'b1; s_rd[1] = 5'd15; s_wdata[1] = 64'hFEDC_BA98_7654_3210;
    step();
    idle(); s_iss_en[1] = 1'b1; s_iss[1] = 5'd15;
    step();
    idle();
    for (int k = 0; k < 3; k++) s_rs_addr[1][k] = 5'd15;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b x15 data%0d", k), b_rdata[k*64 +: 64], 64'hFEDC_BA98_7654_3210);
      check($sformatf("b x15 busy%0d", k), 64'(b_rs_busy[k]), 64'd1);
    end
    step();

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        s_wr_en[d]  = $urandom_range(0, 1) == 1;
        s_iss_en[d] = $urandom_range(0, 1) == 1;
        s_rd[d]     = rnd_addr(d);
        s_iss[d]    = rnd_addr(d);
        s_wdata[d]  = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) s_rs_addr[d][k] = (k < nrd(d)) ? rnd_addr(d) : 5'd0;
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
